// File: rtl/multicycle_control_if.sv
// Memory handshake bundle between the multicycle controller and the unified
// instruction/data memory.
//   mem_req   : controller -> memory, request held until mem_ready
//   mem_we    : controller -> memory, request is a write
//   mem_ready : memory -> controller, current request completes this cycle
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the RV32I core. Sequences each instruction
// through fetch / decode / execute / memory / writeback and drives the
// datapath muxes, write enables and the ALU opcode.
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   mem                 : memory handshake (mem_req, mem_we out; mem_ready in)
//   op, funct3, funct7_5: instruction fields from IR
//   zero, last_bit      : ALU flags (result == 0, result[31])
//   adr_src             : memory address select, 0 PC / 1 ALUOut
//   ir_write, pc_write, reg_write : datapath write enables
//   alu_src_a, alu_src_b, alu_control, result_src, imm_src : datapath selects
//   illegal             : sticky flag, set when an unsupported op/funct3 traps
module multicycle_control (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_control_if.master        mem,
    input  logic [6:0]                  op,
    input  logic [2:0]                  funct3,
    input  logic                        funct7_5,
    input  logic                        zero,
    input  logic                        last_bit,
    output logic                        adr_src,
    output logic                        ir_write,
    output logic                        pc_write,
    output logic                        reg_write,
    output logic [1:0]                  alu_src_a,
    output logic [1:0]                  alu_src_b,
    output logic [2:0]                  alu_control,
    output logic [1:0]                  result_src,
    output logic [1:0]                  imm_src,
    output logic                        illegal
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;
    localparam logic [3:0] TRAP     = 4'd11;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    logic [3:0] state_q, state_d;
    logic       illegal_q;
    logic       mem_req_c, mem_we_c;
    logic [2:0] alu_dec;
    logic       f3_ok;
    logic       taken;

    // ALU decode shared by EXECR and EXECI; only R-type may select sub.
    always_comb begin
        alu_dec = ALU_ADD;
        f3_ok   = 1'b1;
        case (funct3)
            3'b000:  alu_dec = (op == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_dec = ALU_AND;
            3'b110:  alu_dec = ALU_OR;
            default: f3_ok   = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        result_src  = 2'b00;
        imm_src     = IMM_I;
        taken       = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req_c  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                // Precompute the branch/jump target old_pc + imm into ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_BR:   imm_src = IMM_B;
                    OP_JAL:  imm_src = IMM_J;
                    OP_SW:   imm_src = IMM_S;
                    default: imm_src = IMM_I;
                endcase
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BR:        state_d = BRANCH;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (op == OP_SW) ? IMM_S : IMM_I;
                state_d   = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src   = 1'b1;
                if (mem.mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                adr_src   = 1'b1;
                if (mem.mem_ready) state_d = FETCH;
            end
            EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_dec;
                state_d     = f3_ok ? ALUWB : TRAP;
            end
            EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_dec;
                state_d     = f3_ok ? ALUWB : TRAP;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                state_d     = FETCH;
                case (funct3)
                    3'b000:  taken = zero;
                    3'b001:  taken = ~zero;
                    3'b100:  taken = last_bit;
                    default: state_d = TRAP;
                endcase
                pc_write = taken;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = ALUWB;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
        // While reset is held the state sits in FETCH; a high mem_ready must
        // not leak through as an IR/PC load.
        if (reset) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            mem_we_c  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == TRAP) illegal_q <= 1'b1;
        end
    end

    assign mem.mem_req = mem_req_c;
    assign mem.mem_we  = mem_we_c;
    assign illegal     = illegal_q;
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control FSM for the RV32I core: sequences each instruction through fetch, decode, execute, memory and writeback, and drives the ALU's `alu_control` opcode and operand selects. It consumes the ALU's `zero` and `last_bit` flags for branch resolution, and talks to unified instruction/data memory over a req/ready handshake. It sits between the instruction register fields and the datapath muxes/enables.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high; forces state FETCH and clears `illegal`.
- `op` input 7: instruction[6:0] from IR.
- `funct3` input 3: instruction[14:12].
- `funct7_5` input 1: instruction[30].
- `zero` input 1: ALU result == 0.
- `last_bit` input 1: ALU result[31].
- `mem_ready` input 1: memory completes the current request this cycle.
- `mem_req` output 1: memory request, held until `mem_ready`.
- `mem_we` output 1: request is a write.
- `adr_src` output 1: memory address, 0 = PC, 1 = ALUOut.
- `ir_write` output 1: load IR and capture old_pc.
- `pc_write` output 1: load PC from result bus.
- `reg_write` output 1: register file write of result bus into rd.
- `alu_src_a` output 2: 00 PC, 01 old_pc, 10 A (rs1).
- `alu_src_b` output 2: 00 B (rs2), 01 imm, 10 constant 4.
- `alu_control` output 3: 000 add, 001 sub, 010 and, 011 or (ALU's encoding; 111 yields 0).
- `result_src` output 2: 00 ALUOut, 01 memory data, 10 ALU result.
- `imm_src` output 2: 00 I, 01 S, 10 B, 11 J.
- `illegal` output 1: sticky, set on an unsupported opcode or funct3.

## Operation
- Supported instructions: lw (0000011), sw (0100011), R-type (0110011), I-ALU (0010011), branch (1100011, funct3 000 beq / 001 bne / 100 blt), jal (1101111).
- ALU decode for R and I types:
  - funct3 000 gives add; R-type with funct7_5=1 gives sub.
  - funct3 111 gives and; 110 gives or.
  - Any other funct3 is illegal.
- All outputs not listed for a state are 0.
- FETCH: `mem_req`=1, `adr_src`=0. `alu_src_a`=00, `alu_src_b`=10, add, `result_src`=10. On `mem_ready`: `ir_write`=1, `pc_write`=1, go to DECODE. Otherwise stay in FETCH.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, add, so ALUOut = old_pc + imm. `imm_src` is B for branch, J for jal, S for sw, else I. Next state by op:
  - lw/sw to MEMADR.
  - R-type to EXECR.
  - I-ALU to EXECI.
  - branch to BRANCH.
  - jal to JAL.
  - any other op to TRAP.
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, add; `imm_src` I for lw, S for sw. Go to MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: `mem_req`=1, `adr_src`=1. On `mem_ready` go to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1, go to FETCH.
- MEMWRITE: `mem_req`=1, `mem_we`=1, `adr_src`=1. On `mem_ready` go to FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, decoded op. Go to ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, `imm_src`=I, decoded op (never sub). Go to ALUWB.
- An illegal funct3 in EXECR or EXECI goes to TRAP instead of ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1, go to FETCH.
- BRANCH: `alu_src_a`=10, `alu_src_b`=00, sub, `result_src`=00.
  - Taken condition: beq `zero`; bne `!zero`; blt `last_bit` (signed-overflow cases are not corrected).
  - `pc_write` = taken. Go to FETCH.
  - Any other funct3 goes to TRAP with `pc_write`=0.
- JAL: `alu_src_a`=01, `alu_src_b`=10, add, `result_src`=00, `pc_write`=1. Go to ALUWB, which writes old_pc+4 into rd.
- TRAP: `illegal`=1 (registered, sticky). All enables 0. Remain in TRAP until `reset`.

## Timing
- Reset values: state FETCH, `illegal`=0. Because FETCH is a Moore state, `mem_req`=1 and `adr_src`=0 even during reset. All other enables are 0 during reset.
- State register updates on the rising `clk` edge. Outputs are combinational from state, `op`, `funct3`, `funct7_5` and the flags.
- Cycle counts with `mem_ready` tied high:
  - R-type, I-ALU, sw, jal: 4 cycles.
  - lw: 5 cycles.
  - branch: 3 cycles.
- Each wait cycle adds exactly 1 cycle in FETCH, MEMREAD or MEMWRITE.
- `mem_req` stays high and the address source stays stable across wait cycles. `ir_write` and `pc_write` fire only on the `mem_ready` cycle.
- `mem_ready` is ignored in every other state.
- Reset asserted mid-instruction: state goes to FETCH immediately and asynchronously. No write enable may pulse after reset assertion.

## Test plan
- add x3,x1,x2 (op 0110011, f3 000, f7_5 0), `mem_ready`=1 -> states FETCH, DECODE, EXECR, ALUWB. `alu_control`=000 in EXECR; `reg_write`=1 only in cycle 4.
- sub (f7_5 1) -> `alu_control`=001. addi with f7_5 1 -> 000. andi (f3 111) -> 010. ori (f3 110) -> 011.
- lw with `mem_ready` low for 2 cycles in FETCH and 3 in MEMREAD -> total 10 cycles. `mem_req` is continuous and `adr_src`=1 throughout MEMREAD. `reg_write` is asserted once, with `result_src`=01.
- beq: `zero`=1 -> `pc_write`=1 in BRANCH; `zero`=0 -> 0. bne inverts this. blt with `last_bit`=1 -> taken.
- jal -> DECODE `imm_src`=11; JAL `pc_write`=1 with `result_src`=00; ALUWB `reg_write`=1. Total 4 cycles.
- op 1111111 -> TRAP after DECODE, then `illegal`=1 held for 5+ cycles with no `mem_req`. Asserting `reset` mid-MEMREAD returns to FETCH with `illegal`=0 and no `reg_write`.
